// File: rtl/zrb_uart_tx_arbiter_if.sv
// Requester / transmitter bundle for zrb_uart_tx_arbiter.
// Signals:
//   req, req_data, req_last : requester side, byte offered by each requester
//   ack, grant              : arbiter -> requesters, byte latched / current owner
//   tx_start, tx_data       : arbiter -> zrb_uart_tx
//   tx_ready                : zrb_uart_tx -> arbiter
//   busy                    : arbiter not idle
//   timeout_err             : watchdog abort pulse (ZRB_ARB_TIMEOUT_EN only)
// Modports: slave = arbiter view, master = requester/transmitter environment view.
interface zrb_uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   grant;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic               busy;
`ifdef ZRB_ARB_TIMEOUT_EN
  logic               timeout_err;

  modport slave (
    input  req, req_data, req_last, tx_ready,
    output ack, grant, tx_start, tx_data, busy, timeout_err
  );

  modport master (
    output req, req_data, req_last, tx_ready,
    input  ack, grant, tx_start, tx_data, busy, timeout_err
  );
`else
  modport slave (
    input  req, req_data, req_last, tx_ready,
    output ack, grant, tx_start, tx_data, busy
  );

  modport master (
    output req, req_data, req_last, tx_ready,
    input  ack, grant, tx_start, tx_data, busy
  );
`endif
endinterface

// File: rtl/zrb_uart_tx_arbiter.sv
// zrb_uart_tx_arbiter: shares one zrb_uart_tx byte transmitter between N_REQ
// requesters. Round-robin winner selection; the winner keeps the transmitter
// for a burst of up to BURST_LEN bytes, ending early on req_last or req drop.
// Ports:
//   clk      : single clock, posedge
//   reset_n  : asynchronous active-low reset
//   bus      : zrb_uart_tx_arbiter_if.slave (requests, acks, grant, tx handshake, busy)
// Optional feature macro: ZRB_ARB_TIMEOUT_EN adds a 16-bit watchdog on the
// START state (parameter TIMEOUT, port bus.timeout_err).
module zrb_uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned BURST_LEN = 16
`ifdef ZRB_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 1024
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  zrb_uart_tx_arbiter_if.slave    bus
);

  localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  BURST_8 = 8'(BURST_LEN);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
`ifdef ZRB_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_flag_q, last_flag_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic               busy_q;
  logic [IDX_W-1:0]   win_idx;
`ifdef ZRB_ARB_TIMEOUT_EN
  logic [15:0]        wd_q, wd_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  // Round-robin pick: first requester with req=1 scanning from last_owner+1.
  // Scanning downward lets the nearest candidate overwrite farther ones.
  always_comb begin
    int cand;
    cand    = 0;
    win_idx = '0;
    for (int k = int'(N_REQ); k > 0; k--) begin
      cand = (int'(last_owner_q) + k) % int'(N_REQ);
      if (bus.req[cand]) begin
        win_idx = IDX_W'(cand);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ack_d        = '0;
    tx_start_d   = tx_start_q;
    tx_data_d    = tx_data_q;
    last_flag_d  = last_flag_q;
    byte_cnt_d   = byte_cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
`ifdef ZRB_ARB_TIMEOUT_EN
    wd_d          = '0;
    timeout_err_d = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if ((|bus.req) && bus.tx_ready) begin
          state_d     = ST_START;
          owner_d     = win_idx;
          grant_d     = ONE_HOT0 << win_idx;
          ack_d       = ONE_HOT0 << win_idx;
          tx_data_d   = bus.req_data[{win_idx, 3'b000} +: 8];
          last_flag_d = bus.req_last[win_idx];
          byte_cnt_d  = 8'd1;
          tx_start_d  = 1'b1;
        end
      end

      // Hold tx_start until the transmitter shows it has taken the byte.
      ST_START: begin
        if (!bus.tx_ready) begin
          state_d    = ST_WAIT;
          tx_start_d = 1'b0;
        end
`ifdef ZRB_ARB_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          state_d       = ST_IDLE;
          tx_start_d    = 1'b0;
          grant_d       = '0;
          last_owner_d  = owner_q;
          timeout_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end

      // Byte in flight: continue the burst back-to-back or release the owner.
      ST_WAIT: begin
        if (bus.tx_ready) begin
          if (!last_flag_q && (byte_cnt_q < BURST_8) && bus.req[owner_q]) begin
            state_d     = ST_START;
            ack_d       = ONE_HOT0 << owner_q;
            tx_data_d   = bus.req_data[{owner_q, 3'b000} +: 8];
            last_flag_d = bus.req_last[owner_q];
            byte_cnt_d  = byte_cnt_q + 8'd1;
            tx_start_d  = 1'b1;
          end else begin
            state_d      = ST_IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        tx_start_d = 1'b0;
      end
    endcase
  end

  // State register; reset points last_owner at N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      last_flag_q  <= 1'b0;
      byte_cnt_q   <= 8'd0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(N_REQ - 1);
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      last_flag_q  <= last_flag_d;
      byte_cnt_q   <= byte_cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

`ifdef ZRB_ARB_TIMEOUT_EN
  // Watchdog counter and abort pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`endif

  assign bus.ack      = ack_q;
  assign bus.grant    = grant_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;

endmodule
